// File: rtl/sha256_round_core_if.sv
// rtl/sha256_round_core_if.sv - start/result bundle between the hashing top level and the compression engine
interface sha256_round_core_if;
    logic         in_start;
    logic         in_use_iv;
    logic [511:0] in_block;
    logic [255:0] in_hash;
    logic         out_ready;
    logic         out_busy;
    logic         out_valid;
    logic [255:0] out_hash;

    modport master (
        output in_start, in_use_iv, in_block, in_hash,
        input  out_ready, out_busy, out_valid, out_hash
    );

    modport slave (
        input  in_start, in_use_iv, in_block, in_hash,
        output out_ready, out_busy, out_valid, out_hash
    );
endinterface

// File: rtl/sha256_round_core.sv
// rtl/sha256_round_core.sv - SHA-256 compression of one block, ROUNDS_PER_CYCLE chained rounds per clock
module sha256_round_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    sha256_round_core_if.slave bus
);
    localparam int RPC = ROUNDS_PER_CYCLE;
    localparam int ROUND_CYCLES = 64 / RPC;
    localparam logic [5:0] LAST_T = 6'((ROUND_CYCLES - 1) * RPC);

    generate
        if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
            $error("sha256_round_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t       r_state, w_state_nxt;
    logic [5:0]   r_t;
    logic [31:0]  r_chain [8];
    logic [31:0]  r_v [8];
    logic [31:0]  r_w [16];
    logic [255:0] r_hash;
    logic         r_valid;

    logic [255:0] w_init;
    logic [31:0]  w_ext [16 + RPC];
    logic [31:0]  w_s [RPC + 1][8];
    logic [31:0]  w_t1, w_t2;
    logic [5:0]   w_k_idx;

    assign w_init        = bus.in_use_iv ? IV : bus.in_hash;
    assign bus.out_ready = (r_state == IDLE);
    assign bus.out_busy  = (r_state == ROUND) || (r_state == FINAL);
    assign bus.out_valid = r_valid;
    assign bus.out_hash  = r_hash;

    // Window is extended by RPC words so each chained round has its W ready in the same cycle.
    always_comb begin
        w_t1    = '0;
        w_t2    = '0;
        w_k_idx = '0;
        for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
        for (int i = 16; i < 16 + RPC; i++)
            w_ext[i] = ssig1(w_ext[i-2]) + w_ext[i-7] + ssig0(w_ext[i-15]) + w_ext[i-16];
        for (int i = 0; i < 8; i++) w_s[0][i] = r_v[i];
        for (int k = 0; k < RPC; k++) begin
            w_k_idx = r_t + 6'(k);
            w_t1 = w_s[k][7] + bsig1(w_s[k][4]) + ((w_s[k][4] & w_s[k][5]) ^ (~w_s[k][4] & w_s[k][6]))
                 + K[w_k_idx] + w_ext[k];
            w_t2 = bsig0(w_s[k][0]) + ((w_s[k][0] & w_s[k][1]) ^ (w_s[k][0] & w_s[k][2]) ^ (w_s[k][1] & w_s[k][2]));
            w_s[k+1][0] = w_t1 + w_t2;
            w_s[k+1][1] = w_s[k][0];
            w_s[k+1][2] = w_s[k][1];
            w_s[k+1][3] = w_s[k][2];
            w_s[k+1][4] = w_s[k][3] + w_t1;
            w_s[k+1][5] = w_s[k][4];
            w_s[k+1][6] = w_s[k][5];
            w_s[k+1][7] = w_s[k][6];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_start) w_state_nxt = ROUND;
            ROUND:   if (r_t == LAST_T) w_state_nxt = FINAL;
            FINAL:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // r_t is 6 bits, so it wraps back to 0 on the last ROUND edge.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_t     <= '0;
            r_hash  <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_chain[i] <= '0;
                r_v[i]     <= '0;
            end
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_start) begin
                    r_t     <= '0;
                    r_valid <= 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        r_chain[i] <= w_init[255-32*i -: 32];
                        r_v[i]     <= w_init[255-32*i -: 32];
                    end
                    for (int i = 0; i < 16; i++) r_w[i] <= bus.in_block[511-32*i -: 32];
                end
                ROUND: begin
                    r_t <= r_t + 6'(RPC);
                    for (int i = 0; i < 8; i++) r_v[i] <= w_s[RPC][i];
                    for (int i = 0; i < 16; i++) r_w[i] <= w_ext[i+RPC];
                end
                FINAL: begin
                    r_valid <= 1'b1;
                    for (int i = 0; i < 8; i++) r_hash[255-32*i -: 32] <= r_chain[i] + r_v[i];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_round_core.sv
// tb/tb_sha256_round_core.sv - directed-vector bench for sha256_round_core at R = 1, 2, 4, 8
module tb_sha256_round_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sha256_round_core_if if1 ();
    sha256_round_core_if if2 ();
    sha256_round_core_if if4 ();
    sha256_round_core_if if8 ();

    sha256_round_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (.in_clk(clk), .in_rst_n(rst_n), .bus(if1.slave));
    sha256_round_core #(.ROUNDS_PER_CYCLE(2)) u_dut2 (.in_clk(clk), .in_rst_n(rst_n), .bus(if2.slave));
    sha256_round_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (.in_clk(clk), .in_rst_n(rst_n), .bus(if4.slave));
    sha256_round_core #(.ROUNDS_PER_CYCLE(8)) u_dut8 (.in_clk(clk), .in_rst_n(rst_n), .bus(if8.slave));

    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_L1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_L2    = {448'h0, 64'h1c0};
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_L     = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    // Called #1 after an edge with dut1 idle; returns latency (0 on timeout) and the held result.
    task automatic run1(input logic [511:0] blk, input logic iv, input logic [255:0] hin,
                        output int lat, output logic [255:0] hout);
        if1.in_block = blk; if1.in_use_iv = iv; if1.in_hash = hin; if1.in_start = 1'b1;
        @(posedge clk); #1;
        if1.in_start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (if1.out_valid) lat = n;
        end
        hout = if1.out_hash;
    endtask

    task automatic test_reset();
        if1.in_start = 0; if1.in_use_iv = 0; if1.in_block = '0; if1.in_hash = '0;
        if2.in_start = 0; if2.in_use_iv = 0; if2.in_block = '0; if2.in_hash = '0;
        if4.in_start = 0; if4.in_use_iv = 0; if4.in_block = '0; if4.in_hash = '0;
        if8.in_start = 0; if8.in_use_iv = 0; if8.in_block = '0; if8.in_hash = '0;
        #1;
        checks++; if (if1.out_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", if1.out_ready); end
        checks++; if (if1.out_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", if1.out_busy); end
        checks++; if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", if1.out_valid); end
        checks++; if (if1.out_hash !== 256'h0) begin failures++; $display("FAIL reset_hash got=%h want=0", if1.out_hash); end
        checks++; if (if8.out_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_r8 got=%b want=1", if8.out_ready); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        int lat; logic [255:0] h;
        run1(BLK_EMPTY, 1'b1, 256'h0, lat, h);
        checks++; if (lat != 65) begin failures++; $display("FAIL empty_latency got=%0d want=65", lat); end
        checks++; if (h !== DIG_EMPTY) begin failures++; $display("FAIL empty_hash got=%h want=%h", h, DIG_EMPTY); end
    endtask

    task automatic test_abc_all_r();
        int l1, l2, l4, l8;
        l1 = 0; l2 = 0; l4 = 0; l8 = 0;
        if1.in_block = BLK_ABC; if1.in_use_iv = 1; if1.in_start = 1;
        if2.in_block = BLK_ABC; if2.in_use_iv = 1; if2.in_start = 1;
        if4.in_block = BLK_ABC; if4.in_use_iv = 1; if4.in_start = 1;
        if8.in_block = BLK_ABC; if8.in_use_iv = 1; if8.in_start = 1;
        @(posedge clk); #1;
        if1.in_start = 0; if2.in_start = 0; if4.in_start = 0; if8.in_start = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (if1.out_valid && l1 == 0) l1 = n;
            if (if2.out_valid && l2 == 0) l2 = n;
            if (if4.out_valid && l4 == 0) l4 = n;
            if (if8.out_valid && l8 == 0) l8 = n;
        end
        checks++; if (l1 != 65) begin failures++; $display("FAIL abc_lat_r1 got=%0d want=65", l1); end
        checks++; if (l2 != 33) begin failures++; $display("FAIL abc_lat_r2 got=%0d want=33", l2); end
        checks++; if (l4 != 17) begin failures++; $display("FAIL abc_lat_r4 got=%0d want=17", l4); end
        checks++; if (l8 != 9) begin failures++; $display("FAIL abc_lat_r8 got=%0d want=9", l8); end
        checks++; if (if1.out_hash !== DIG_ABC) begin failures++; $display("FAIL abc_hash_r1 got=%h want=%h", if1.out_hash, DIG_ABC); end
        checks++; if (if2.out_hash !== DIG_ABC) begin failures++; $display("FAIL abc_hash_r2 got=%h want=%h", if2.out_hash, DIG_ABC); end
        checks++; if (if4.out_hash !== DIG_ABC) begin failures++; $display("FAIL abc_hash_r4 got=%h want=%h", if4.out_hash, DIG_ABC); end
        checks++; if (if8.out_hash !== DIG_ABC) begin failures++; $display("FAIL abc_hash_r8 got=%h want=%h", if8.out_hash, DIG_ABC); end
    endtask

    task automatic test_two_block();
        int lat1, lat2; logic [255:0] h1, h2;
        run1(BLK_L1, 1'b1, 256'h0, lat1, h1);
        run1(BLK_L2, 1'b0, h1, lat2, h2);
        checks++; if (lat1 != 65 || lat2 != 65) begin failures++; $display("FAIL two_block_lat got=%0d,%0d want=65,65", lat1, lat2); end
        checks++; if (h2 !== DIG_L) begin failures++; $display("FAIL two_block_hash got=%h want=%h", h2, DIG_L); end
    endtask

    task automatic test_ignore_start();
        int lat;
        lat = 0;
        if1.in_block = BLK_ABC; if1.in_use_iv = 1; if1.in_start = 1;
        @(posedge clk); #1;
        if1.in_start = 0;
        if1.in_block = {16{32'hdeadbeef}}; if1.in_use_iv = 0; if1.in_hash = {8{32'h12345678}};
        checks++; if (if1.out_ready !== 1'b0 || if1.out_busy !== 1'b1 || if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL ign_after_accept got=rdy%b busy%b val%b want=rdy0 busy1 val0", if1.out_ready, if1.out_busy, if1.out_valid);
        end
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 10) if1.in_start = 1;
            if (n == 11) if1.in_start = 0;
            if (n == 64) if1.in_start = 1;
            if (if1.out_valid) begin lat = n; if1.in_start = 0; end
        end
        checks++; if (lat != 65) begin failures++; $display("FAIL ign_latency got=%0d want=65", lat); end
        checks++; if (if1.out_hash !== DIG_ABC) begin failures++; $display("FAIL ign_hash got=%h want=%h", if1.out_hash, DIG_ABC); end
        @(posedge clk); #1;
        checks++; if (if1.out_ready !== 1'b1 || if1.out_valid !== 1'b1) begin
            failures++; $display("FAIL ign_no_queue got=rdy%b val%b want=rdy1 val1", if1.out_ready, if1.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        lat = 0;
        if1.in_block = BLK_ABC; if1.in_use_iv = 1; if1.in_start = 1;
        @(posedge clk); #1;
        if1.in_start = 0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (if1.out_ready !== 1'b1 || if1.out_busy !== 1'b0 || if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_ctrl got=rdy%b busy%b val%b want=rdy1 busy0 val0", if1.out_ready, if1.out_busy, if1.out_valid);
        end
        checks++; if (if1.out_hash !== 256'h0) begin failures++; $display("FAIL rst_mid_hash got=%h want=0", if1.out_hash); end
        if1.in_start = 1;
        @(posedge clk); #1;
        checks++; if (if1.out_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_held got=%b want=0", if1.out_busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if1.in_start = 0;
        checks++; if (if1.out_busy !== 1'b1) begin failures++; $display("FAIL rst_release_accept got=%b want=1", if1.out_busy); end
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (if1.out_valid) lat = n;
        end
        checks++; if (lat != 65) begin failures++; $display("FAIL rst_restart_lat got=%0d want=65", lat); end
        checks++; if (if1.out_hash !== DIG_ABC) begin failures++; $display("FAIL rst_restart_hash got=%h want=%h", if1.out_hash, DIG_ABC); end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int nacc;
        logic prev_busy, done;
        nacc = 0; done = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        if1.in_block = BLK_ABC; if1.in_use_iv = 1; if1.in_start = 1;
        prev_busy = if1.out_busy;
        for (int n = 1; n <= 400 && !done; n++) begin
            @(posedge clk); #1;
            if (if1.out_busy && !prev_busy && nacc < 3) begin
                acc[nacc] = n;
                checks++; if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop idx=%0d got=%b want=0", nacc, if1.out_valid); end
                nacc++;
                if (nacc == 3) if1.in_start = 0;
            end
            prev_busy = if1.out_busy;
            if (nacc == 3 && if1.out_valid) done = 1;
        end
        checks++; if (nacc != 3 || !done) begin failures++; $display("FAIL b2b_count got=%0d accepts done=%b want=3 done=1", nacc, done); end
        checks++; if (acc[1] - acc[0] != 66) begin failures++; $display("FAIL b2b_spacing1 got=%0d want=66", acc[1] - acc[0]); end
        checks++; if (acc[2] - acc[1] != 66) begin failures++; $display("FAIL b2b_spacing2 got=%0d want=66", acc[2] - acc[1]); end
        checks++; if (if1.out_hash !== DIG_ABC) begin failures++; $display("FAIL b2b_hash got=%h want=%h", if1.out_hash, DIG_ABC); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc_all_r();
        test_two_block();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
